// File: rtl/bexkat1_ifetch_pkg.sv
// Shared types and defaults for the bexkat1 instruction fetch unit.
// Queue entries carry the widest supported pc; the top narrows it to ADDR_W.
package bexkat1_ifetch_pkg;

    localparam int DEFAULT_ADDR_W = 15;
    localparam int DEFAULT_DEPTH  = 4;
    localparam int MAX_ADDR_W     = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] pc;
        logic [31:0]           ins;
    } fetch_entry_t;

endpackage

// File: rtl/bexkat1_ifetch_fifo.sv
// Instruction queue: synchronous push/pop/flush with a registered head entry.
// The head register is loaded from storage or the incoming word; nothing bypasses to the output combinationally.
module bexkat1_ifetch_fifo
    import bexkat1_ifetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    fetch_entry_t     head_reg;
    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] slot_we;

    assign do_pop  = pop && (count_reg != '0) && !flush;
    assign do_push = push && !flush && ((count_reg != CNT_W'(DEPTH)) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                mem[i] <= push_entry;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
            // Next head is either the already-stored successor or the word arriving into an (about to be) empty queue.
            if (do_pop && (count_reg > CNT_W'(1))) begin
                head_reg <= mem[rd_ptr_reg + PTR_W'(1)];
            end else if (do_push && ((count_reg == '0) || do_pop)) begin
                head_reg <= push_entry;
            end
        end
    end

    assign count = count_reg;
    assign head  = head_reg;

endmodule

// File: rtl/bexkat1_ifetch.sv
// Read-only Wishbone fetch master feeding an instruction queue, one outstanding transfer at a time.
// A redirect during an unacked transfer drains that transfer before fetching from the new pc.
module bexkat1_ifetch
    import bexkat1_ifetch_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                DEPTH    = DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [3:0]        sel_o,
    output logic [ADDR_W-1:0] adr_o,
    input  logic [31:0]       dat_i,
    input  logic              ack_i,
    output logic              ins_valid_o,
    output logic [31:0]       ins_o,
    output logic [ADDR_W-1:0] ins_pc_o,
    input  logic              ins_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic [ADDR_W-1:0] fetch_pc_inc;
    logic [ADDR_W-1:0] adr_reg;
    logic [ADDR_W-1:0] adr_next;
    logic              cyc_reg;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;
    logic              has_room;
    logic              ins_valid;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign ins_valid    = (count != '0);
    assign push         = (state_reg == S_BUS) && ack_i && !redirect_i;
    assign pop          = ins_valid && ins_ready_i && !redirect_i;
    assign count_next   = count + CNT_W'(push) - CNT_W'(pop);
    assign has_room     = (count_next < CNT_W'(DEPTH));
    assign fetch_pc_inc = fetch_pc_reg + ADDR_W'(1);
    assign push_entry   = '{pc: MAX_ADDR_W'(fetch_pc_reg), ins: dat_i};

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        adr_next      = adr_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_next = redirect_pc_i;
                end else if (has_room) begin
                    state_next = S_BUS;
                    adr_next   = fetch_pc_reg;
                end
            end
            S_BUS: begin
                if (redirect_i) begin
                    fetch_pc_next = redirect_pc_i;
                    // An acked word is simply dropped; an unacked one must still be waited out.
                    state_next    = ack_i ? S_IDLE : S_DRAIN;
                end else if (ack_i) begin
                    fetch_pc_next = fetch_pc_inc;
                    if (has_room) begin
                        adr_next = fetch_pc_inc;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (redirect_i) begin
                    fetch_pc_next = redirect_pc_i;
                end
                if (ack_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            fetch_pc_reg <= RESET_PC;
            adr_reg      <= RESET_PC;
            cyc_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            adr_reg      <= adr_next;
            cyc_reg      <= (state_next != S_IDLE);
        end
    end

    bexkat1_ifetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (redirect_i),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign cyc_o       = cyc_reg;
    assign stb_o       = cyc_reg;
    assign we_o        = 1'b0;
    assign sel_o       = 4'hf;
    assign adr_o       = adr_reg;
    assign ins_valid_o = ins_valid;
    assign ins_o       = head.ins;
    assign ins_pc_o    = ADDR_W'(head.pc);

endmodule
